// File: rtl/pwm_timing_calc.sv
// -----------------------------------------------------------------------------
// pwm_timing_calc
//
// Converts a stream of (pulse width, phase) pairs, one per transducer, into
// 8-bit rise/fall edge times for the downstream pwm_generator instances.
// Results are collected in a shadow bank. A complete frame is copied
// atomically into the output bank on the edge where time_cnt == 255, so every
// generator starts the next PWM period (time_cnt == 0) with a coherent frame.
//
// Optional feature macro: PWM_TIMING_CALC_OVERRUN_EN
//   When defined, adds the sticky 'overrun' output. It is set by any attempt
//   to push data (din_valid) while din_ready is low.
//
// Ports:
//   clk           in   system clock (shared with pwm_generator)
//   rst_n         in   asynchronous active-low reset
//   time_cnt      in   [7:0] free-running PWM period counter
//   din_valid     in   pulse width / phase pair is valid
//   din_ready     out  block can accept an element
//   pulse_width   in   [7:0] high time in counts
//   phase         in   [7:0] pulse centre in counts
//   rise          out  [DEPTH*8-1:0] committed rise times, transducer i at [8i+7:8i]
//   fall          out  [DEPTH*8-1:0] committed fall times, same packing
//   frame_pending out  a complete frame is waiting for the period boundary
//   overrun       out  sticky push-while-not-ready flag (macro builds only)
// -----------------------------------------------------------------------------
module pwm_timing_calc #(
    parameter int DEPTH = 249
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           time_cnt,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic [7:0]           pulse_width,
    input  logic [7:0]           phase,
    output logic [DEPTH*8-1:0]   rise,
    output logic [DEPTH*8-1:0]   fall,
`ifdef PWM_TIMING_CALC_OVERRUN_EN
    output logic                 frame_pending,
    output logic                 overrun
`else
    output logic                 frame_pending
`endif
);

    localparam int                IDX_W    = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    // Rise edge: pulse is centred on phase, so it starts half a width early.
    function automatic logic [7:0] calc_rise(input logic [7:0] ph, input logic [7:0] pw);
        calc_rise = ph - {1'b0, pw[7:1]};
    endfunction

    // Fall edge: exactly pw counts after rise; a wrap past 255 is legal and
    // means the pulse straddles the period boundary.
    function automatic logic [7:0] calc_fall(input logic [7:0] r, input logic [7:0] pw);
        calc_fall = r + pw;
    endfunction

    state_t               state_r;
    state_t               state_next_s;
    logic [IDX_W-1:0]     idx_r;
    logic [IDX_W-1:0]     idx_next_s;
    logic                 din_ready_r;
    logic                 ready_next_s;
    logic                 commit_s;
    logic                 accept_s;

    logic                 pipe_valid_r;
    logic [7:0]           pipe_rise_r;
    logic [7:0]           pipe_fall_r;
    logic [IDX_W-1:0]     pipe_idx_r;

    logic [DEPTH*8-1:0]   shadow_rise_r;
    logic [DEPTH*8-1:0]   shadow_fall_r;
    logic [DEPTH*8-1:0]   rise_r;
    logic [DEPTH*8-1:0]   fall_r;

    assign accept_s      = din_valid & din_ready_r;
    assign din_ready     = din_ready_r;
    assign frame_pending = (state_r == ST_PENDING);
    assign rise          = rise_r;
    assign fall          = fall_r;

    // Next-state, write index, ready and commit decode.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        ready_next_s = din_ready_r;
        commit_s     = 1'b0;
        case (state_r)
            ST_COLLECT: begin
                if (accept_s) begin
                    idx_next_s = idx_r + IDX_W'(1);
                    // Ready drops right after the last element of the frame.
                    if (idx_r == LAST_IDX) begin
                        ready_next_s = 1'b0;
                    end else begin
                        ready_next_s = 1'b1;
                    end
                end else begin
                    idx_next_s   = idx_r;
                    ready_next_s = din_ready_r;
                end
                // The frame is complete once its last entry reaches the shadow bank.
                if (pipe_valid_r && (pipe_idx_r == LAST_IDX)) begin
                    state_next_s = ST_PENDING;
                end else begin
                    state_next_s = ST_COLLECT;
                end
            end
            ST_PENDING: begin
                if (time_cnt == 8'd255) begin
                    commit_s     = 1'b1;
                    state_next_s = ST_COLLECT;
                    idx_next_s   = {IDX_W{1'b0}};
                    ready_next_s = 1'b1;
                end else begin
                    commit_s     = 1'b0;
                    state_next_s = ST_PENDING;
                end
            end
            default: begin
                state_next_s = ST_COLLECT;
                idx_next_s   = {IDX_W{1'b0}};
                ready_next_s = 1'b1;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_COLLECT;
            idx_r       <= {IDX_W{1'b0}};
            din_ready_r <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            idx_r       <= idx_next_s;
            din_ready_r <= ready_next_s;
        end
    end

    // Single pipeline stage holding the computed edges and their transducer index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid_r <= 1'b0;
            pipe_rise_r  <= 8'd0;
            pipe_fall_r  <= 8'd0;
            pipe_idx_r   <= {IDX_W{1'b0}};
        end else begin
            pipe_valid_r <= accept_s;
            if (accept_s) begin
                pipe_rise_r <= calc_rise(phase, pulse_width);
                pipe_fall_r <= calc_fall(calc_rise(phase, pulse_width), pulse_width);
                pipe_idx_r  <= idx_r;
            end
        end
    end

    // Shadow bank: one entry written per pipeline result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_rise_r <= '0;
            shadow_fall_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pipe_valid_r && (pipe_idx_r == IDX_W'(i))) begin
                    shadow_rise_r[i*8 +: 8] <= pipe_rise_r;
                    shadow_fall_r[i*8 +: 8] <= pipe_fall_r;
                end
            end
        end
    end

    // Output bank: changes only on a commit edge or on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_r <= '0;
            fall_r <= '0;
        end else if (commit_s) begin
            rise_r <= shadow_rise_r;
            fall_r <= shadow_fall_r;
        end
    end

`ifdef PWM_TIMING_CALC_OVERRUN_EN
    logic overrun_r;

    assign overrun = overrun_r;

    // Sticky flag for data offered while the block was not ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_r <= 1'b0;
        end else if (din_valid && !din_ready_r) begin
            overrun_r <= 1'b1;
        end
    end
`endif

endmodule
